// File: rtl/mult_hilo_pkg.sv
// Shared op encodings, controller states and default latency for the HI/LO multiply sequencer.
// No logic; no latency.
// No flow control.
package mult_hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MFHI  = 3'd3;
    localparam logic [2:0] OP_MFLO  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int DEFAULT_LATENCY = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mult_hilo_ctrl_multiply.sv
// Combinational signed 32x32 -> 64 multiplier; outputs forced to zero when not enabled.
// Zero-cycle latency.
// No flow control.
module multiply (
    input  logic        enable,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic signed [63:0] prod;

    assign prod     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign {hi, lo} = enable ? prod : 64'd0;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register owner: sequences MULT/MULTU through the shared multiplier and serves moves.
// Multiply: HI/LO written LATENCY edges after accept; moves complete on the edge after accept.
// op_ready drops for the whole multiply; the requester must hold its op until op_ready returns.
module mult_hilo_ctrl
    import mult_hilo_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       opa;
    logic [31:0]       opb;
    logic              is_unsigned;
    logic [31:0]       hi;
    logic [31:0]       lo;
    logic [31:0]       mul_hi;
    logic [31:0]       mul_lo;
    logic [31:0]       hi_unsigned;

    multiply u_multiply (
        .enable (state == ST_BUSY),
        .a      (opa),
        .b      (opb),
        .hi     (mul_hi),
        .lo     (mul_lo)
    );

    // Signed product reinterpreted as unsigned: each negative operand contributes the other at 2^32.
    assign hi_unsigned = mul_hi + (opa[31] ? opb : 32'd0) + (opb[31] ? opa : 32'd0);

    assign op_ready = (state == ST_IDLE);
    assign busy     = (state == ST_BUSY);
    assign hi_out   = hi;
    assign lo_out   = lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            opa         <= '0;
            opb         <= '0;
            is_unsigned <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MULT, OP_MULTU: begin
                                opa         <= rs_val;
                                opb         <= rt_val;
                                is_unsigned <= (op_code == OP_MULTU);
                                cnt         <= CNT_INIT;
                                state       <= ST_BUSY;
                            end
                            OP_MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        hi    <= is_unsigned ? hi_unsigned : mul_hi;
                        lo    <= mul_lo;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
